// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and state encoding for the UART command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Opcode bytes as they appear on the wire
  localparam logic [7:0] OP_PIXEL = 8'h01;
  localparam logic [7:0] OP_BG    = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  // Encodings presented on cmd_op
  localparam logic [1:0] CMD_PIXEL = 2'd1;
  localparam logic [1:0] CMD_BG    = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  // Payload byte counts per opcode
  localparam logic [2:0] LEN_PIXEL = 3'd5;
  localparam logic [2:0] LEN_BG    = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    PAYLOAD,
    CHECK,
    OUT
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: received-frame input and drawing-command output bundle.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready on the command side; the frame side cannot be stalled.
interface uart_cmd_parser_if;
  logic [8:0] frame;
  logic       frame_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x;
  logic [9:0] cmd_y;
  logic [7:0] cmd_color;
  logic       err;
  logic [7:0] err_count;
  logic       overrun;

  // Parser side: consumes frames, produces commands and status
  modport master (
    input  frame, frame_valid, cmd_ready,
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, err, err_count, overrun
  );

  // Environment side: UART receiver plus VGA command consumer
  modport slave (
    output frame, frame_valid, cmd_ready,
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, err, err_count, overrun
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout: inter-byte silence counter; expire flags the last allowed idle cycle.
// Latency: expire is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; holds at the expiry value until cleared.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [CW-1:0] cnt_q;

  assign expire = en && (cnt_q == CW'(TIMEOUT_TICKS - 1));

  // Count idle cycles while enabled; clear wins over counting
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles UART bytes into validated VGA drawing commands.
// Latency: cmd_valid rises the cycle after the final byte of an accepted packet.
// Backpressure: command held while cmd_ready is low; frames arriving then are dropped and set overrun.
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per packet.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 4096,
  parameter int unsigned H_MAX         = 640,
  parameter int unsigned V_MAX         = 480
) (
  input logic               clk_16bd,
  input logic               rst,
  uart_cmd_parser_if.master bus
);

  logic [7:0] rx_byte;
  logic       rx_err;

  assign rx_byte = bus.frame[7:0];
  assign rx_err  = bus.frame[8];

  state_t     state_q, state_d;

  // Shadow fields assembled from the payload; copied to the outputs only on acceptance
  logic [1:0] op_q, op_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] color_q, color_d;
  logic [2:0] cnt_q, cnt_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] xsum_q, xsum_d;
`endif

  logic       abort;
  logic       done;
  logic       load_out;
  logic       drop;
  logic       tmo_en;
  logic       tmo_clr;
  logic       tmo_expire;

  logic [1:0] cmd_op_q;
  logic [9:0] cmd_x_q;
  logic [9:0] cmd_y_q;
  logic [7:0] cmd_color_q;
  logic       err_q;
  logic [7:0] err_count_q;
  logic       overrun_q;

  // Silence is only policed while a packet is partially received
  assign tmo_en  = (state_q == OPCODE) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign tmo_clr = bus.frame_valid || (state_d != state_q) || !tmo_en;

  uart_cmd_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk_16bd(clk_16bd),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expire  (tmo_expire)
  );

  // State register
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, field assembly and abort decision
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    cnt_d    = cnt_q;
`ifdef UART_CMD_CHECKSUM_EN
    xsum_d   = xsum_q;
`endif
    abort    = 1'b0;
    done     = 1'b0;
    load_out = 1'b0;
    drop     = 1'b0;

    case (state_q)
      IDLE: begin
        // Errored or non-sync bytes are line noise between packets, not errors
        if (bus.frame_valid && !rx_err && (rx_byte == SYNC_BYTE)) begin
          state_d = OPCODE;
        end
      end

      OPCODE: begin
        if (bus.frame_valid) begin
          if (rx_err) begin
            abort = 1'b1;
          end else begin
`ifdef UART_CMD_CHECKSUM_EN
            xsum_d = rx_byte;
`endif
            case (rx_byte)
              OP_PIXEL: begin
                op_d    = CMD_PIXEL;
                cnt_d   = LEN_PIXEL;
                state_d = PAYLOAD;
              end
              OP_BG: begin
                op_d    = CMD_BG;
                cnt_d   = LEN_BG;
                state_d = PAYLOAD;
              end
              OP_CLEAR: begin
                op_d = CMD_CLEAR;
`ifdef UART_CMD_CHECKSUM_EN
                state_d = CHECK;
`else
                done = 1'b1;
`endif
              end
              default: abort = 1'b1;
            endcase
          end
        end else if (tmo_expire) begin
          abort = 1'b1;
        end
      end

      PAYLOAD: begin
        if (bus.frame_valid) begin
          if (rx_err) begin
            abort = 1'b1;
          end else begin
            // The remaining count identifies the field; the last byte is always colour
            case (cnt_q)
              3'd5:    x_d[9:8] = rx_byte[1:0];
              3'd4:    x_d[7:0] = rx_byte;
              3'd3:    y_d[9:8] = rx_byte[1:0];
              3'd2:    y_d[7:0] = rx_byte;
              default: color_d  = rx_byte;
            endcase
            cnt_d = cnt_q - 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
            xsum_d = xsum_q ^ rx_byte;
`endif
            if (cnt_q == 3'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
              state_d = CHECK;
`else
              done = 1'b1;
`endif
            end
          end
        end else if (tmo_expire) begin
          abort = 1'b1;
        end
      end

`ifdef UART_CMD_CHECKSUM_EN
      CHECK: begin
        if (bus.frame_valid) begin
          if (rx_err || (rx_byte != xsum_q)) begin
            abort = 1'b1;
          end else begin
            done = 1'b1;
          end
        end else if (tmo_expire) begin
          abort = 1'b1;
        end
      end
`endif

      OUT: begin
        // No buffering behind the held command: anything arriving now is lost
        if (bus.frame_valid) begin
          drop = 1'b1;
        end
        if (bus.cmd_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Coordinates are only range-checked once the whole pixel packet is in
    if (done) begin
      if ((op_d == CMD_PIXEL) &&
          (({22'd0, x_d} >= H_MAX) || ({22'd0, y_d} >= V_MAX))) begin
        abort = 1'b1;
      end else begin
        state_d  = OUT;
        load_out = 1'b1;
      end
    end

    if (abort) begin
      state_d = IDLE;
    end
  end

  // Packet assembly registers
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      op_q    <= 2'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      color_q <= 8'd0;
      cnt_q   <= 3'd0;
`ifdef UART_CMD_CHECKSUM_EN
      xsum_q  <= 8'd0;
`endif
    end else begin
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
`ifdef UART_CMD_CHECKSUM_EN
      xsum_q  <= xsum_d;
`endif
    end
  end

  // Command outputs and status; fields an opcode does not carry keep their old value
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      cmd_op_q    <= 2'd0;
      cmd_x_q     <= 10'd0;
      cmd_y_q     <= 10'd0;
      cmd_color_q <= 8'd0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      err_q <= abort;
      if (abort && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (load_out) begin
        cmd_op_q <= op_d;
        if (op_d == CMD_PIXEL) begin
          cmd_x_q <= x_d;
          cmd_y_q <= y_d;
        end
        if (op_d != CMD_CLEAR) begin
          cmd_color_q <= color_d;
        end
      end
    end
  end

  assign bus.cmd_valid = (state_q == OUT);
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_x     = cmd_x_q;
  assign bus.cmd_y     = cmd_y_q;
  assign bus.cmd_color = cmd_color_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed vectors with hand-computed expectations for uart_cmd_parser.
// Latency: checks cmd_valid the cycle after the final byte and err timing at timeout expiry.
// Backpressure: holds cmd_ready low with incoming traffic to exercise overrun.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 32;

  logic clk_16bd = 1'b0;
  logic rst      = 1'b1;

  int n_chk = 0;
  int n_bad = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_TICKS(TMO),
    .H_MAX        (640),
    .V_MAX        (480)
  ) dut (
    .clk_16bd(clk_16bd),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_16bd = ~clk_16bd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One frame per two cycles; returns on the falling edge just after it was sampled
  task automatic send_byte(input logic [7:0] b, input logic e);
    @(negedge clk_16bd);
    bus.frame       = {e, b};
    bus.frame_valid = 1'b1;
    @(negedge clk_16bd);
    bus.frame_valid = 1'b0;
  endtask

  // Full packet; payload bytes are taken from the top of pl, checksum appended when enabled
  task automatic send_cmd(input logic [7:0] op, input int n, input logic [39:0] pl);
    logic [7:0] cs;
    logic [7:0] b;
    cs = op;
    send_byte(8'hA5, 1'b0);
    send_byte(op, 1'b0);
    for (int i = 0; i < n; i++) begin
      b  = pl[39 - 8*i -: 8];
      cs = cs ^ b;
      send_byte(b, 1'b0);
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cs, 1'b0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, 32'(bus.cmd_valid), 0);
    check_val({tag, "_op"},    32'(bus.cmd_op), 0);
    check_val({tag, "_x"},     32'(bus.cmd_x), 0);
    check_val({tag, "_y"},     32'(bus.cmd_y), 0);
    check_val({tag, "_color"}, 32'(bus.cmd_color), 0);
    check_val({tag, "_err"},   32'(bus.err), 0);
    check_val({tag, "_errcnt"}, 32'(bus.err_count), 0);
    check_val({tag, "_ovr"},   32'(bus.overrun), 0);
  endtask

  initial begin
    logic        stable;
    logic [29:0] snap;

    bus.frame       = 9'd0;
    bus.frame_valid = 1'b0;
    bus.cmd_ready   = 1'b0;

    repeat (3) @(negedge clk_16bd);
    check_all_zero("reset");
    rst = 1'b0;

    // Pixel x=0x13F=319, y=0x1DF=479, colour 0x1C, held by cmd_ready=0
    send_cmd(8'h01, 5, {8'h01, 8'h3F, 8'h01, 8'hDF, 8'h1C});
    check_val("pix_valid", 32'(bus.cmd_valid), 1);
    check_val("pix_op",    32'(bus.cmd_op), 1);
    check_val("pix_x",     32'(bus.cmd_x), 319);
    check_val("pix_y",     32'(bus.cmd_y), 479);
    check_val("pix_color", 32'(bus.cmd_color), 32'h1C);
    check_val("pix_err",   32'(bus.err), 0);

    // Backpressure with traffic: command must not move, overrun must set
    stable = 1'b1;
    snap   = {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_color};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_16bd);
      if (!bus.cmd_valid || ({bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_color} != snap))
        stable = 1'b0;
      bus.frame       = {1'b0, 8'h55};
      bus.frame_valid = ((i % 2) == 0);
    end
    @(negedge clk_16bd);
    bus.frame_valid = 1'b0;
    check_val("bp_stable",  32'(stable), 1);
    check_val("bp_valid",   32'(bus.cmd_valid), 1);
    check_val("bp_overrun", 32'(bus.overrun), 1);
    check_val("bp_errcnt",  32'(bus.err_count), 0);
    bus.cmd_ready = 1'b1;
    @(negedge clk_16bd);
    check_val("bp_release", 32'(bus.cmd_valid), 0);

    // Bad opcode
    send_byte(8'hA5, 1'b0);
    send_byte(8'h07, 1'b0);
    check_val("badop_err",    32'(bus.err), 1);
    check_val("badop_errcnt", 32'(bus.err_count), 1);
    @(negedge clk_16bd);
    check_val("badop_pulse",  32'(bus.err), 0);

    // x = 0x280 = 640 is out of range
    send_cmd(8'h01, 5, {8'h02, 8'h80, 8'h00, 8'h00, 8'h00});
    check_val("x640_err",    32'(bus.err), 1);
    check_val("x640_errcnt", 32'(bus.err_count), 2);
    check_val("x640_valid",  32'(bus.cmd_valid), 0);

    // Receive error inside a packet
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b1);
    check_val("rxerr_errcnt", 32'(bus.err_count), 3);

    // Silence after A5 02: abort lands exactly TMO cycles after the last byte
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (TMO - 1) @(negedge clk_16bd);
    check_val("tmo_early", 32'(bus.err), 0);
    @(negedge clk_16bd);
    check_val("tmo_pulse",  32'(bus.err), 1);
    check_val("tmo_errcnt", 32'(bus.err_count), 4);

    // Clear after timeout; x/y/colour keep the earlier pixel values
    send_cmd(8'h03, 0, 40'd0);
    check_val("clr_valid", 32'(bus.cmd_valid), 1);
    check_val("clr_op",    32'(bus.cmd_op), 3);
    check_val("clr_color", 32'(bus.cmd_color), 32'h1C);
    check_val("clr_x",     32'(bus.cmd_x), 319);

    // Byte landing on the expiry cycle is processed, not aborted
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (TMO - 2) @(negedge clk_16bd);
    send_byte(8'h33, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h31, 1'b0);
`endif
    check_val("coin_valid",  32'(bus.cmd_valid), 1);
    check_val("coin_op",     32'(bus.cmd_op), 2);
    check_val("coin_color",  32'(bus.cmd_color), 32'h33);
    check_val("coin_x",      32'(bus.cmd_x), 319);
    check_val("coin_errcnt", 32'(bus.err_count), 4);

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hE2, 1'b0);
    check_val("cs_ok_valid", 32'(bus.cmd_valid), 1);
    check_val("cs_ok_color", 32'(bus.cmd_color), 32'hE0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hE3, 1'b0);
    check_val("cs_bad_err",    32'(bus.err), 1);
    check_val("cs_bad_errcnt", 32'(bus.err_count), 5);
`endif

    // Saturation
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5, 1'b0);
      send_byte(8'h07, 1'b0);
    end
    check_val("sat_errcnt", 32'(bus.err_count), 255);

    // Reset mid-packet, then a boundary pixel x=0x27F=639, y=479
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk_16bd);
    check_all_zero("midrst");
    rst = 1'b0;
    send_cmd(8'h01, 5, {8'h02, 8'h7F, 8'h01, 8'hDF, 8'h1C});
    check_val("x639_valid",  32'(bus.cmd_valid), 1);
    check_val("x639_op",     32'(bus.cmd_op), 1);
    check_val("x639_x",      32'(bus.cmd_x), 639);
    check_val("x639_y",      32'(bus.cmd_y), 479);
    check_val("x639_errcnt", 32'(bus.err_count), 0);

    @(negedge clk_16bd);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
